lcd_byte_writer: RTL and testbench

- Downstream of the LCD init/command controller; drives the 4-bit character LCD pins.
- Accepts one 8-bit command or data byte per valid/ready handshake and sends it as two nibbles, upper first.
- Generates the setup, enable-pulse, hold, inter-nibble and post-write delays at 50 MHz.
- Lets the controller issue whole bytes instead of hand-timing each nibble.

---
 rtl/lcd_pkg.sv | 37 +++
 rtl/lcd_write_fifo.sv | 54 +++++
 rtl/lcd_byte_writer.sv | 150 +++++++++++++++
 tb/tb_lcd_byte_writer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and default 50 MHz timing for the 4-bit LCD byte writer.
package lcd_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StUpperSetup,
        StUpperPulse,
        StUpperHold,
        StGap,
        StLowerSetup,
        StLowerPulse,
        StLowerHold,
        StWait
    } state_e;

    localparam int unsigned DefSetupCycles     = 2;
    localparam int unsigned DefPulseCycles     = 12;
    localparam int unsigned DefHoldCycles      = 1;
    localparam int unsigned DefNibbleGapCycles = 50;
    localparam int unsigned DefCmdWaitCycles   = 2000;
    localparam int unsigned DefLongWaitCycles  = 82000;
    localparam int unsigned DefFifoDepth       = 4;

    localparam logic [7:0] CmdClear         = 8'h01;
    localparam logic [7:0] CmdReturnHome    = 8'h02;
    localparam logic [7:0] CmdReturnHomeAlt = 8'h03;

    localparam logic RsCmd  = 1'b0;
    localparam logic RsData = 1'b1;

    // Clear and Return Home need the long post-write wait; data bytes never do.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return (rs == RsCmd) &&
               ((b == CmdClear) || (b == CmdReturnHome) || (b == CmdReturnHomeAlt));
    endfunction

endpackage

// File: rtl/lcd_write_fifo.sv
// Small synchronous FIFO holding {RS, byte} requests ahead of the nibble FSM.
module lcd_write_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             next_full,
    output logic             next_empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [PtrW-1:0]  wr_q, rd_q;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full, do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full     = (cnt_q == CntW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign cnt_d    = cnt_q + CntW'(do_push) - CntW'(do_pop);
    assign next_full  = (cnt_d == CntW'(DEPTH));
    assign next_empty = (cnt_d == '0);
    assign pop_data = mem_q[rd_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) wr_q <= ptr_inc(wr_q);
            if (do_pop)  rd_q <= ptr_inc(rd_q);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

endmodule

// File: rtl/lcd_byte_writer.sv
// Sends one byte to a 4-bit HD44780-style LCD as two timed nibbles, upper first.
// Define LCD_WRITER_FIFO_EN to buffer requests in an lcd_write_fifo.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES      = DefSetupCycles,
    parameter int unsigned PULSE_CYCLES      = DefPulseCycles,
    parameter int unsigned HOLD_CYCLES       = DefHoldCycles,
    parameter int unsigned NIBBLE_GAP_CYCLES = DefNibbleGapCycles,
    parameter int unsigned CMD_WAIT_CYCLES   = DefCmdWaitCycles,
    parameter int unsigned LONG_WAIT_CYCLES  = DefLongWaitCycles
`ifdef LCD_WRITER_FIFO_EN
    , parameter int unsigned FIFO_DEPTH      = DefFifoDepth
`endif
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iValid,
    input  logic       iRegisterSelect,
    input  logic [7:0] iData,
    output logic       oReady,
    output logic       oDone,
    output logic       oBusy,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic [3:0] oLCD_Data
);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d, state_len;
    logic [7:0]  byte_q, byte_d, in_byte;
    logic [3:0]  data_q, data_d;
    logic        rs_q, rs_d, in_rs;
    logic        e_q, e_d, ready_q, ready_d, done_q, done_d, busy_q, busy_d;
    logic        have_byte, pending_next, last;

`ifdef LCD_WRITER_FIFO_EN
    logic       fifo_empty, fifo_next_full, fifo_next_empty;
    logic [8:0] fifo_out;

    lcd_write_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (Clock),
        .rst        (Reset),
        .push       (iValid && ready_q),
        .push_data  ({iRegisterSelect, iData}),
        .pop        ((state_q == StIdle) && !fifo_empty),
        .pop_data   (fifo_out),
        .empty      (fifo_empty),
        .next_full  (fifo_next_full),
        .next_empty (fifo_next_empty)
    );

    assign have_byte    = !fifo_empty;
    assign in_byte      = fifo_out[7:0];
    assign in_rs        = fifo_out[8];
    assign ready_d      = !fifo_next_full;
    assign pending_next = !fifo_next_empty;
`else
    assign have_byte    = iValid && ready_q;
    assign in_byte      = iData;
    assign in_rs        = iRegisterSelect;
    assign ready_d      = (state_d == StIdle);
    assign pending_next = 1'b0;
`endif

    always_comb begin
        state_len = 32'd1;
        unique case (state_q)
            StUpperSetup, StLowerSetup: state_len = SETUP_CYCLES;
            StUpperPulse, StLowerPulse: state_len = PULSE_CYCLES;
            StUpperHold,  StLowerHold:  state_len = HOLD_CYCLES;
            StGap:                      state_len = NIBBLE_GAP_CYCLES;
            StWait: state_len = is_long_cmd(rs_q, byte_q) ? LONG_WAIT_CYCLES : CMD_WAIT_CYCLES;
            default:                    state_len = 32'd1;
        endcase
    end

    assign last = (cnt_q == state_len - 32'd1);

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        rs_d    = rs_q;
        unique case (state_q)
            StIdle: begin
                if (have_byte) begin
                    state_d = StUpperSetup;
                    byte_d  = in_byte;
                    rs_d    = in_rs;
                end
            end
            StUpperSetup: if (last) state_d = StUpperPulse;
            StUpperPulse: if (last) state_d = StUpperHold;
            StUpperHold:  if (last) state_d = StGap;
            StGap:        if (last) state_d = StLowerSetup;
            StLowerSetup: if (last) state_d = StLowerPulse;
            StLowerPulse: if (last) state_d = StLowerHold;
            StLowerHold:  if (last) state_d = StWait;
            StWait:       if (last) state_d = StIdle;
            default:      state_d = StIdle;
        endcase

        cnt_d = ((state_d != state_q) || (state_d == StIdle)) ? 32'd0 : cnt_q + 32'd1;

        // Outputs are computed from the next state so the pins line up with state_q.
        e_d    = (state_d == StUpperPulse) || (state_d == StLowerPulse);
        data_d = data_q;
        if (state_d == StUpperSetup)      data_d = byte_d[7:4];
        else if (state_d == StLowerSetup) data_d = byte_d[3:0];
        done_d = (state_q == StWait) && last;
        busy_d = (state_d != StIdle) || pending_next;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            byte_q  <= '0;
            rs_q    <= 1'b0;
            data_q  <= '0;
            e_q     <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            e_q     <= e_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign oReady              = ready_q;
    assign oDone               = done_q;
    assign oBusy               = busy_q;
    assign oLCD_Enabled        = e_q;
    assign oLCD_RegisterSelect = rs_q;
    assign oLCD_ReadWrite      = 1'b0;
    assign oLCD_Data           = data_q;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Directed bench for lcd_byte_writer: nibble timing, wait lengths, handshake and reset.
module tb_lcd_byte_writer;
    import lcd_pkg::*;

    // Long wait shortened so the run stays small; all other timing is the 50 MHz default.
    localparam int unsigned LongWait = 5000;
    localparam int unsigned CmdWait  = 2000;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       iValid = 1'b0;
    logic       iRegisterSelect = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       oReady, oDone, oBusy, oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite;
    logic [3:0] oLCD_Data;

    always #5 Clock = ~Clock;

    lcd_byte_writer #(
        .LONG_WAIT_CYCLES (LongWait)
    ) dut (
        .Clock               (Clock),
        .Reset               (Reset),
        .iValid              (iValid),
        .iRegisterSelect     (iRegisterSelect),
        .iData               (iData),
        .oReady              (oReady),
        .oDone               (oDone),
        .oBusy               (oBusy),
        .oLCD_Enabled        (oLCD_Enabled),
        .oLCD_RegisterSelect (oLCD_RegisterSelect),
        .oLCD_ReadWrite      (oLCD_ReadWrite),
        .oLCD_Data           (oLCD_Data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Caller has presented the byte at a negedge with oReady high; accept edge is the next
    // posedge. Cycle k is the k-th negedge after it.
    task automatic observe_byte(input string tag, input logic rs, input logic [7:0] b,
                                input int wait_len, input logic nv, input logic [7:0] nd,
                                input int inject_at);
        int         rise[2] = '{-1, -1};
        int         hi[2]   = '{0, 0};
        logic [3:0] nib[2]  = '{4'h0, 4'h0};
        logic       rsp[2]  = '{1'b0, 1'b0};
        int         n_rise = 0, done_k = -1, ready_bad = 0, busy_bad = 0;
        logic       e_prev = 1'b0, done_ready = 1'b0, done_busy = 1'b1;
        logic [3:0] done_data = 4'h0;
        check_eq({tag, ".ready_pre"}, 32'(oReady), 32'd1);
        @(posedge Clock);
        #1;
        iValid = nv;
        iData  = nd;
        for (int k = 1; k <= wait_len + 90; k++) begin
            @(negedge Clock);
            if (inject_at != 0 && k == inject_at) begin
                iValid = 1'b1;
                iData  = 8'h55;
            end
            if (inject_at != 0 && k == inject_at + 10) iValid = 1'b0;
            if (oDone) begin
                done_k     = k;
                done_ready = oReady;
                done_busy  = oBusy;
                done_data  = oLCD_Data;
                break;
            end
            if (oReady) ready_bad++;
            if (!oBusy) busy_bad++;
            if (oLCD_Enabled && !e_prev) begin
                if (n_rise < 2) begin
                    rise[n_rise] = k;
                    nib[n_rise]  = oLCD_Data;
                    rsp[n_rise]  = oLCD_RegisterSelect;
                end
                n_rise++;
            end
            if (oLCD_Enabled && n_rise >= 1 && n_rise <= 2) hi[n_rise-1]++;
            e_prev = oLCD_Enabled;
        end
        check_eq({tag, ".rise_count"}, 32'(n_rise), 32'd2);
        check_eq({tag, ".rise_upper"}, 32'(rise[0]), 32'd3);
        check_eq({tag, ".rise_lower"}, 32'(rise[1]), 32'd68);
        check_eq({tag, ".e_high_upper"}, 32'(hi[0]), 32'd12);
        check_eq({tag, ".e_high_lower"}, 32'(hi[1]), 32'd12);
        check_eq({tag, ".nibble_upper"}, 32'(nib[0]), 32'(b[7:4]));
        check_eq({tag, ".nibble_lower"}, 32'(nib[1]), 32'(b[3:0]));
        check_eq({tag, ".rs_upper"}, 32'(rsp[0]), 32'(rs));
        check_eq({tag, ".rs_lower"}, 32'(rsp[1]), 32'(rs));
        check_eq({tag, ".done_cycle"}, 32'(done_k), 32'(81 + wait_len));
        check_eq({tag, ".ready_while_busy"}, 32'(ready_bad), 32'd0);
        check_eq({tag, ".busy_gaps"}, 32'(busy_bad), 32'd0);
        check_eq({tag, ".ready_at_done"}, 32'(done_ready), 32'd1);
        check_eq({tag, ".busy_at_done"}, 32'(done_busy), 32'd0);
        check_eq({tag, ".data_held"}, 32'(done_data), 32'(b[3:0]));
    endtask

    // Watches an idle stretch: no E pulse, no oDone, no busy.
    task automatic expect_quiet(input string tag, input int cycles);
        int rises = 0, dones = 0, busys = 0;
        logic e_prev = oLCD_Enabled;
        for (int k = 0; k < cycles; k++) begin
            @(negedge Clock);
            if (oLCD_Enabled && !e_prev) rises++;
            if (oDone) dones++;
            if (oBusy) busys++;
            e_prev = oLCD_Enabled;
        end
        check_eq({tag, ".e_rises"}, 32'(rises), 32'd0);
        check_eq({tag, ".dones"}, 32'(dones), 32'd0);
        check_eq({tag, ".busy"}, 32'(busys), 32'd0);
    endtask

`ifdef LCD_WRITER_FIFO_EN
    logic [7:0] sent[$];
    logic [3:0] nibs[$];
`endif

    initial begin
        #1 Reset = 1'b1;
        #2;
        check_eq("reset.e", 32'(oLCD_Enabled), 32'd0);
        check_eq("reset.data", 32'(oLCD_Data), 32'd0);
        check_eq("reset.rs", 32'(oLCD_RegisterSelect), 32'd0);
        check_eq("reset.ready", 32'(oReady), 32'd0);
        check_eq("reset.done", 32'(oDone), 32'd0);
        check_eq("reset.busy", 32'(oBusy), 32'd0);
        check_eq("reset.rw", 32'(oLCD_ReadWrite), 32'd0);
        repeat (3) @(negedge Clock);
        check_eq("reset.ready_held", 32'(oReady), 32'd0);
        Reset = 1'b0;
        @(negedge Clock);
        check_eq("release.ready", 32'(oReady), 32'd1);

`ifdef LCD_WRITER_FIFO_EN
        begin
            int dones = 0;
            logic e_prev = 1'b0;
            for (int k = 0; k < 5 * 2081 + 200; k++) begin
                if (k < 5) begin
                    iValid          = 1'b1;
                    iRegisterSelect = RsData;
                    iData           = 8'h30 + 8'(k);
                    if (oReady) sent.push_back(iData);
                end else begin
                    iValid = 1'b0;
                end
                @(negedge Clock);
                if (oLCD_Enabled && !e_prev) nibs.push_back(oLCD_Data);
                if (oDone) dones++;
                e_prev = oLCD_Enabled;
            end
            check_eq("fifo.accepted_min", 32'(sent.size() >= 4), 32'd1);
            check_eq("fifo.dones", 32'(dones), 32'(sent.size()));
            check_eq("fifo.nibbles", 32'(nibs.size()), 32'(2 * sent.size()));
            for (int i = 0; i < sent.size() && 2 * i + 1 < nibs.size(); i++)
                check_eq("fifo.byte_order", 32'({nibs[2*i], nibs[2*i+1]}), 32'(sent[i]));
        end
`else
        // Reset during the upper E pulse abandons the byte.
        iValid = 1'b1;
        iRegisterSelect = RsData;
        iData = 8'h41;
        @(posedge Clock);
        #1 iValid = 1'b0;
        repeat (5) @(negedge Clock);
        check_eq("midreset.e_before", 32'(oLCD_Enabled), 32'd1);
        #2 Reset = 1'b1;
        #1;
        check_eq("midreset.e_dropped", 32'(oLCD_Enabled), 32'd0);
        check_eq("midreset.busy", 32'(oBusy), 32'd0);
        check_eq("midreset.ready", 32'(oReady), 32'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check_eq("midreset.ready_after", 32'(oReady), 32'd1);
        expect_quiet("midreset.quiet", 2200);

        iValid = 1'b1; iRegisterSelect = RsData; iData = 8'h41;
        observe_byte("data_41", RsData, 8'h41, CmdWait, 1'b0, 8'h00, 0);

        iValid = 1'b1; iRegisterSelect = RsCmd; iData = CmdClear;
        observe_byte("cmd_clear", RsCmd, CmdClear, LongWait, 1'b0, 8'h00, 0);

        iValid = 1'b1; iRegisterSelect = RsCmd; iData = CmdReturnHomeAlt;
        observe_byte("cmd_home3", RsCmd, CmdReturnHomeAlt, LongWait, 1'b0, 8'h00, 0);

        iValid = 1'b1; iRegisterSelect = RsCmd; iData = 8'h04;
        observe_byte("cmd_04", RsCmd, 8'h04, CmdWait, 1'b0, 8'h00, 0);

        // Same code as Clear but on the data register, with a request poked in during WAIT.
        iValid = 1'b1; iRegisterSelect = RsData; iData = 8'h01;
        observe_byte("data_01", RsData, 8'h01, CmdWait, 1'b0, 8'h00, 100);
        expect_quiet("ignored", 300);

        iValid = 1'b1; iRegisterSelect = RsCmd; iData = 8'h28;
        observe_byte("b2b_28", RsCmd, 8'h28, CmdWait, 1'b1, 8'h0C, 0);
        observe_byte("b2b_0c", RsCmd, 8'h0C, CmdWait, 1'b0, 8'h00, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
